s247_job_scheduler: RTL and testbench
=====================================

S247_JOB_SCHEDULER -- requirements
Module: s247_job_scheduler

Interface
REQ-001 SHALL have parameter NUM_CORES, default 8, number of Pathfinder cores scheduled.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, job-descriptor FIFO entries (power of two).
REQ-003 SHALL have port wb_clk_i  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port wb_rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports wbs_stb_i, wbs_cyc_i, wbs_we_i  input  1 each  Wishbone slave strobe, cycle, write enable.
REQ-006 SHALL have ports wbs_sel_i  input  4; wbs_dat_i  input  32; wbs_adr_i  input  32  Wishbone byte select, write data, address.
REQ-007 SHALL have ports wbs_ack_o  output  1; wbs_dat_o  output  32  Wishbone acknowledge, read data.
REQ-008 SHALL have port core_valid_o  output  NUM_CORES  one-hot job offer per core.
REQ-009 SHALL have port core_ready_i  input  NUM_CORES  core accepts offered job.
REQ-010 SHALL have port core_job_o  output  32  descriptor shared by all cores, meaningful only under core_valid_o.
REQ-011 SHALL have port core_done_i  input  NUM_CORES  single-cycle job-complete pulse per core.
REQ-012 SHALL have port irq_o  output  1  level interrupt.

Function
REQ-013 SHALL decode wbs_adr_i[3:2]: 0 JOB (W), 1 STATUS (R), 2 DONE (R/W1C), 3 CTRL (R/W; bit0 enable, bit1 irq_en); other address bits ignored; wbs_sel_i ignored (full-word access only).
REQ-014 SHALL assert wbs_ack_o exactly one cycle after a cycle with stb&cyc&!ack, for one cycle; reads return data in that ack cycle; register side effects take effect on the ack cycle.
REQ-015 SHALL push wbs_dat_i into the FIFO on an acked JOB write when not full; if full, drop the data and set sticky overflow.
REQ-016 SHALL return STATUS = {16'b0, overflow, full, empty, count[4:0] zero-extended, busy[NUM_CORES-1:0]} packed as [15]=overflow,[14]=full,[13]=empty,[12:8]=count,[7:0]=busy; STATUS read clears overflow.
REQ-017 SHALL evaluate full/empty from start-of-cycle state; simultaneous push and pop when not full both occur, count unchanged.
REQ-018 SHALL run dispatch FSM IDLE -> ISSUE: in IDLE, if enable & !empty & any core with !busy, select the first free core searching upward (with wrap) from rr_ptr+1, go to ISSUE next cycle.
REQ-019 SHALL in ISSUE drive core_valid_o one-hot at the selected core and core_job_o = FIFO head, held stable until core_ready_i[sel]; on that handshake cycle: pop FIFO, set busy[sel], rr_ptr <= sel, return to IDLE.
REQ-020 SHALL never withdraw core_valid_o before handshake; clearing enable during ISSUE takes effect only on return to IDLE.
REQ-021 SHALL on core_done_i[i] with busy[i] clear busy[i] and set done[i]; done pulse on a non-busy core is ignored.
REQ-022 SHALL, if DONE W1C and a new done[i] occur in the same cycle, leave done[i] set.
REQ-023 SHALL allow a core freed by core_done_i to be selected from the following IDLE evaluation (one-cycle minimum gap).
REQ-024 SHALL drive irq_o = irq_en & |done, registered (one-cycle delay from done/irq_en change).
REQ-025 SHALL issue at most one job per two cycles (IDLE+ISSUE minimum).

Reset
REQ-026 SHALL on wb_rst_i (any state, including mid-ISSUE or mid-Wishbone cycle) force: FSM IDLE, FIFO empty, count 0, busy 0, done 0, overflow 0, enable 0, irq_en 0, rr_ptr NUM_CORES-1, wbs_ack_o 0, wbs_dat_o 0, core_valid_o 0, core_job_o 0, irq_o 0.
REQ-027 SHALL hold outputs at reset values the cycle after wb_rst_i deasserts; first transaction accepted that cycle.

Verification
REQ-028 Push 0xA1,0xA2 with enable=1, all cores ready -> core 0 receives 0xA1, core 1 receives 0xA2; STATUS busy=0x03, count=0.
REQ-029 Enable=0, push 5 jobs (depth 4) -> STATUS full=1, count=4, overflow=1; second STATUS read shows overflow=0.
REQ-030 Offer to core 2 with core_ready_i[2]=0 for 10 cycles -> core_valid_o=0x04, core_job_o stable 10 cycles; pops only on ready.
REQ-031 irq_en=1, core_done_i[0] pulse while busy -> DONE=0x01, irq_o high next cycle; W1C 0x01 -> irq_o low; W1C coincident with new done[0] -> done[0] remains 1.
REQ-032 All 8 cores busy, 1 job queued -> no valid; core_done_i[5] -> next issue to core 5.
REQ-033 Assert wb_rst_i during ISSUE with 3 jobs queued -> next cycle core_valid_o=0, STATUS=0x2000 (empty=1).

Source files
------------

// File: rtl/s247_job_scheduler.sv
// s247_job_scheduler: Wishbone-fed job FIFO dispatching descriptors round-robin to free cores
module s247_job_scheduler #(
    parameter int NUM_CORES  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_we_i,
    input  logic [3:0]           wbs_sel_i,
    input  logic [31:0]          wbs_dat_i,
    input  logic [31:0]          wbs_adr_i,
    output logic                 wbs_ack_o,
    output logic [31:0]          wbs_dat_o,
    output logic [NUM_CORES-1:0] core_valid_o,
    input  logic [NUM_CORES-1:0] core_ready_i,
    output logic [31:0]          core_job_o,
    input  logic [NUM_CORES-1:0] core_done_i,
    output logic                 irq_o
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t               state, state_n;
    logic [31:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic [NUM_CORES-1:0] busy, done, sel_onehot;
    logic [PW-1:0]        rr_ptr, sel, pick, idx;
    logic                 found, overflow, enable, irq_en;
    logic                 req, push, pop, full, empty;
    logic                 wr_job, rd_stat, wr_done, wr_ctrl;
    logic [31:0]          rdata, status;
    logic                 unused;

    assign unused = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0]};

    assign req     = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign wr_job  = req & wbs_we_i & (wbs_adr_i[3:2] == 2'd0);
    assign rd_stat = req & ~wbs_we_i & (wbs_adr_i[3:2] == 2'd1);
    assign wr_done = req & wbs_we_i & (wbs_adr_i[3:2] == 2'd2);
    assign wr_ctrl = req & wbs_we_i & (wbs_adr_i[3:2] == 2'd3);

    assign full       = count == (AW+1)'(FIFO_DEPTH);
    assign empty      = count == '0;
    assign push       = wr_job & ~full;
    assign pop        = (state == ISSUE) & core_ready_i[sel];
    assign sel_onehot = NUM_CORES'(1) << sel;

    assign status = {16'b0, overflow, full, empty, 5'(count), 8'(busy)};
    assign rdata  = (wbs_adr_i[3:2] == 2'd1) ? status :
                    (wbs_adr_i[3:2] == 2'd2) ? 32'(done) :
                    (wbs_adr_i[3:2] == 2'd3) ? {30'b0, irq_en, enable} : '0;

    // Walk downward so the nearest free core after rr_ptr is the last one written.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = NUM_CORES; k >= 1; k--) begin
            idx = PW'((int'(rr_ptr) + k) % NUM_CORES);
            if (!busy[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = (state == IDLE) ? ((enable && !empty && found) ? ISSUE : IDLE)
                                  : (core_ready_i[sel] ? IDLE : ISSUE);
    end

    always_comb begin
        core_valid_o = (state == ISSUE) ? sel_onehot : '0;
        core_job_o   = (state == ISSUE) ? mem[rd_ptr] : '0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr] <= wbs_dat_i;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            busy      <= '0;
            done      <= '0;
            irq_o     <= 1'b0;
            enable    <= 1'b0;
            irq_en    <= 1'b0;
            sel       <= '0;
            rr_ptr    <= PW'(NUM_CORES - 1);
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req && !wbs_we_i) ? rdata : '0;
            wr_ptr    <= wr_ptr + AW'(push);
            rd_ptr    <= rd_ptr + AW'(pop);
            count     <= count + (AW+1)'(push) - (AW+1)'(pop);
            overflow  <= (overflow & ~rd_stat) | (wr_job & full);
            busy      <= (busy & ~core_done_i) | (pop ? sel_onehot : '0);
            // A fresh completion wins over a same-cycle write-one-to-clear.
            done      <= (done & ~(wr_done ? wbs_dat_i[NUM_CORES-1:0] : '0)) | (core_done_i & busy);
            irq_o     <= irq_en & |done;
            if (wr_ctrl) {irq_en, enable} <= wbs_dat_i[1:0];
            if (state == IDLE) sel <= pick;
            if (pop) rr_ptr <= sel;
        end
    end
endmodule

// File: tb/tb_s247_job_scheduler.sv
// tb_s247_job_scheduler: queue-based reference model plus directed and random traffic for the job scheduler
module tb_s247_job_scheduler;
    localparam int N  = 8;
    localparam int FD = 4;

    logic          clk = 1'b0, rst = 1'b1;
    logic          wbs_stb = 1'b0, wbs_cyc = 1'b0, wbs_we = 1'b0;
    logic [3:0]    wbs_sel = 4'hf;
    logic [31:0]   wbs_dat_i = '0, wbs_adr = '0;
    logic          wbs_ack;
    logic [31:0]   wbs_dat_o;
    logic [N-1:0]  core_valid, core_ready = '0, core_done = '0;
    logic [31:0]   core_job;
    logic          irq;

    int n_chk = 0, n_fail = 0;
    bit rnd_on;

    always #5 clk = ~clk;

    s247_job_scheduler #(.NUM_CORES(N), .FIFO_DEPTH(FD)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(wbs_stb), .wbs_cyc_i(wbs_cyc), .wbs_we_i(wbs_we),
        .wbs_sel_i(wbs_sel), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr),
        .wbs_ack_o(wbs_ack), .wbs_dat_o(wbs_dat_o),
        .core_valid_o(core_valid), .core_ready_i(core_ready),
        .core_job_o(core_job), .core_done_i(core_done), .irq_o(irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: jobs as a queue, cores as bit sets, one outstanding offer.
    logic [31:0]  jq[$], rd_exp[$];
    logic [N-1:0] m_busy, m_done, nd;
    logic         m_ovf, m_en, m_irqen, m_ack, m_rd, m_irq, m_off, m_live = 1'b0, req, hs;
    int           m_core, m_rr, sz0, pk;

    function automatic int pick(input logic [N-1:0] b, input int rr);
        for (int k = 1; k <= N; k++) if (!b[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (m_live) begin
            chk("ack", 32'(wbs_ack), 32'(m_ack));
            chk("core_valid", 32'(core_valid), m_off ? (32'd1 << m_core) : 32'd0);
            chk("core_job", core_job, m_off ? jq[0] : 32'd0);
            chk("irq", 32'(irq), 32'(m_irq));
            if (m_ack && m_rd) begin
                if (rd_exp.size() == 0) chk("rdata_unexpected", wbs_dat_o, 32'hdead_beef);
                else chk("rdata", wbs_dat_o, rd_exp.pop_front());
            end
        end
        if (rst) begin
            jq.delete(); rd_exp.delete();
            m_busy = '0; m_done = '0; m_ovf = 0; m_en = 0; m_irqen = 0;
            m_ack = 0; m_rd = 0; m_irq = 0; m_off = 0; m_core = 0; m_rr = N - 1;
            m_live = 1'b1;
        end else if (m_live) begin
            sz0   = jq.size();
            req   = wbs_stb & wbs_cyc & !m_ack;
            hs    = m_off && core_ready[m_core];
            pk    = pick(m_busy, m_rr);
            nd    = core_done & m_busy;
            m_irq = m_irqen & |m_done;
            if (req && !wbs_we)
                rd_exp.push_back(wbs_adr[3:2] == 2'd1 ? {16'b0, m_ovf, sz0 == FD, sz0 == 0, 5'(sz0), m_busy} :
                                 wbs_adr[3:2] == 2'd2 ? 32'(m_done) :
                                 wbs_adr[3:2] == 2'd3 ? {30'b0, m_irqen, m_en} : 32'd0);
            if (req && !wbs_we && wbs_adr[3:2] == 2'd1) m_ovf = 0;
            if (req && wbs_we && wbs_adr[3:2] == 2'd0) begin
                if (sz0 < FD) jq.push_back(wbs_dat_i);
                else m_ovf = 1;
            end
            m_done = (m_done & ~((req && wbs_we && wbs_adr[3:2] == 2'd2) ? wbs_dat_i[N-1:0] : '0)) | nd;
            m_busy = m_busy & ~core_done;
            if (hs) begin
                void'(jq.pop_front());
                m_busy[m_core] = 1'b1;
                m_rr = m_core;
                m_off = 0;
            end else if (!m_off && m_en && sz0 > 0 && pk >= 0) begin
                m_off = 1;
                m_core = pk;
            end
            if (req && wbs_we && wbs_adr[3:2] == 2'd3) {m_irqen, m_en} = wbs_dat_i[1:0];
            m_ack = req;
            m_rd  = req && !wbs_we;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wb(input logic w, input logic [1:0] a, input logic [31:0] d, output logic [31:0] r);
        wbs_stb = 1; wbs_cyc = 1; wbs_we = w; wbs_dat_i = d;
        wbs_sel = 4'($urandom());
        wbs_adr = ($urandom() & 32'hFFFF_FFF0) | 32'({a, 2'b00});
        r = 'x;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (wbs_ack) begin r = wbs_dat_o; break; end
        end
        n_chk++;
        if (!wbs_ack) begin
            n_fail++;
            $display("FAIL wb_ack_timeout: no ack for adr %0d at %0t", a, $time);
        end
        wbs_stb = 0; wbs_cyc = 0;
    endtask

    task automatic wbw(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] r;
        wb(1'b1, a, d, r);
    endtask

    task automatic wbr(input logic [1:0] a, output logic [31:0] r);
        wb(1'b0, a, 32'd0, r);
    endtask

    task automatic pulse(input logic [N-1:0] m);
        core_done = m; @(posedge clk); #1; core_done = '0;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 20; i++) begin
            if (core_valid != '0) return;
            @(posedge clk); #1;
        end
        n_chk++; n_fail++;
        $display("FAIL %s: no core offer within 20 cycles at %0t", name, $time);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        wbr(2'd1, r); chk("status_after_reset", r, 32'h0000_2000);
        wbr(2'd3, r); chk("ctrl_after_reset", r, 32'h0);

        core_ready = '1;
        wbw(2'd3, 32'h1);
        wbw(2'd0, 32'hA1);
        wbw(2'd0, 32'hA2);
        idle(6);
        wbr(2'd1, r); chk("status_two_jobs", r, 32'h0000_2003);

        core_ready = '0;
        wbw(2'd0, 32'hB2);
        wait_valid("offer_core2");
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 32'(core_valid), 32'h04);
            chk("stall_job", core_job, 32'hB2);
            idle(1);
        end
        wbr(2'd1, r); chk("status_stalled", r, 32'h0000_0103);
        core_ready = 8'h04;
        idle(2);
        wbr(2'd1, r); chk("status_after_ready", r, 32'h0000_2007);

        wbw(2'd3, 32'h0);
        for (int i = 0; i < 5; i++) wbw(2'd0, 32'hC0 + 32'(i));
        wbr(2'd1, r); chk("status_overflow", r, 32'h0000_C407);
        wbr(2'd1, r); chk("status_overflow_cleared", r, 32'h0000_4407);

        wbw(2'd3, 32'h2);
        pulse(8'h01);
        idle(1);
        wbr(2'd2, r); chk("done_core0", r, 32'h1);
        chk("irq_high", 32'(irq), 32'h1);
        wbw(2'd2, 32'h1);
        idle(2);
        chk("irq_low", 32'(irq), 32'h0);
        pulse(8'h80);
        idle(1);
        wbr(2'd2, r); chk("done_idle_core_ignored", r, 32'h0);
        idle(1);
        fork
            wbw(2'd2, 32'h2);
            pulse(8'h02);
        join
        wbr(2'd2, r); chk("done_w1c_collision", r, 32'h2);

        core_ready = '1;
        wbw(2'd3, 32'h3);
        idle(12);
        wbw(2'd0, 32'hD0); wbw(2'd0, 32'hD1); wbw(2'd0, 32'hD2);
        idle(8);
        wbw(2'd0, 32'hD3);
        idle(3);
        for (int i = 0; i < 4; i++) begin
            chk("all_busy_no_offer", 32'(core_valid), 32'h0);
            idle(1);
        end
        wbr(2'd1, r); chk("status_all_busy", r, 32'h0000_01FF);
        pulse(8'h20);
        wait_valid("offer_core5");
        chk("freed_core5_valid", 32'(core_valid), 32'h20);
        chk("freed_core5_job", core_job, 32'hD3);

        idle(2);
        pulse(8'h04);
        core_ready = '0;
        wbw(2'd0, 32'hE0); wbw(2'd0, 32'hE1); wbw(2'd0, 32'hE2);
        wait_valid("offer_before_reset");
        chk("pre_reset_job", core_job, 32'hE0);
        rst = 1; idle(1); rst = 0;
        chk("reset_valid", 32'(core_valid), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        wbr(2'd1, r); chk("status_mid_issue_reset", r, 32'h0000_2000);
        wbr(2'd2, r); chk("done_after_reset", r, 32'h0);

        wbw(2'd3, 32'h3);
        rnd_on = 1;
        fork
            while (rnd_on) begin
                @(posedge clk); #1;
                core_ready = N'($urandom());
                core_done  = ($urandom_range(0, 3) == 0) ? (N'(1) << $urandom_range(0, N - 1)) : '0;
            end
            begin
                for (int k = 0; k < 200; k++) begin
                    int op = $urandom_range(0, 9);
                    if (op < 4) wbw(2'd0, $urandom());
                    else if (op < 6) wbr(2'd1, r);
                    else if (op == 6) wbr(2'd2, r);
                    else if (op == 7) wbw(2'd2, $urandom());
                    else if (op == 8) wbw(2'd3, {30'b0, 1'($urandom()), 1'($urandom_range(0, 4) != 0)});
                    else wbr(2'($urandom_range(0, 3)), r);
                end
                rnd_on = 0;
            end
        join
        core_done = '0;
        core_ready = '1;
        wbw(2'd3, 32'h1);
        idle(30);
        wbr(2'd1, r);
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
